result_demux4: RTL
==================

RESULT_DEMUX4 -- requirements
Module: result_demux4

Interface
REQ-001 Parameter WIDTH, default 32, data width of the input word and of each output channel.
REQ-002 Parameter CNTW, default 16, width of the accepted-transfer counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  result word to be routed.
REQ-006 in_valid  input  1  in_data, s1 and S0 are valid this cycle.
REQ-007 s1, S0  input  1 each  destination select; {s1,S0} = 2'b00..2'b11 selects channel 0..3.
REQ-008 in_ready  output  1  block can accept a word for the selected channel this cycle.
REQ-009 o0, o1, o2, o3  output  WIDTH each  registered channel data.
REQ-010 o_valid  output  4  bit k set means channel k holds an undelivered word.
REQ-011 o_ready  input  4  bit k set means the consumer of channel k takes the word this cycle.
REQ-012 xfer_count  output  CNTW  number of accepted input words, modulo 2^CNTW.
REQ-013 busy  output  1  OR of all o_valid bits.

Function
REQ-014 Each channel k SHALL have a one-entry holding register (data plus valid flag).
REQ-015 in_ready SHALL be combinational: !o_valid[sel] | o_ready[sel], where sel = {s1,S0}; it SHALL NOT depend on in_valid.
REQ-016 An input word is accepted when in_valid & in_ready are both high at a rising clk edge.
REQ-017 On accept, channel sel data SHALL load in_data and o_valid[sel] SHALL be 1 from the next cycle (latency 1 cycle, no combinational data path in to out).
REQ-018 A channel word is delivered when o_valid[k] & o_ready[k] are both high at a rising clk edge; o_valid[k] then SHALL clear unless REQ-019 applies.
REQ-019 If accept to channel k and delivery from channel k occur at the same edge, o_valid[k] SHALL stay 1 and ok SHALL take the new word (full throughput, one word per cycle per channel).
REQ-020 Delivery on any channel SHALL be independent of, and simultaneous with, accept or delivery on any other channel.
REQ-021 When channel sel is full and o_ready[sel] = 0, in_ready SHALL be 0; no word SHALL be dropped or overwritten, and other channels SHALL be unaffected.
REQ-022 ok SHALL hold its last value while o_valid[k] = 0 and while stalled; it changes only on accept to channel k.
REQ-023 xfer_count SHALL increment by 1 on each accept and wrap from 2^CNTW-1 to 0.
REQ-024 s1/S0 values when in_valid = 0 SHALL have no effect on state.
REQ-025 Select is 2-bit and fully decoded; no invalid-select case exists.

Reset
REQ-026 While rst_n = 0, asynchronously: o_valid = 4'b0000, o0..o3 = 0, xfer_count = 0, busy = 0.
REQ-027 An accept or delivery pending at the edge where rst_n falls SHALL be discarded; state SHALL be as in REQ-026.
REQ-028 After rst_n rises, the first accept SHALL be possible at the first rising clk edge.

Verification
REQ-029 Reset, o_ready = 4'b1111, send 0xA0000000..0xA0000003 with sel 0,1,2,3 on consecutive cycles -> each appears on o0..o3 one cycle later with o_valid one-hot for one cycle; xfer_count = 4.
REQ-030 o_ready[2] = 0; send 0x11111111 then 0x22222222 to sel 2 -> first accepted, in_ready = 0 on the second cycle; o2 = 0x11111111 held; raise o_ready[2] -> 0x11111111 delivered, 0x22222222 accepted the same edge, o2 = 0x22222222 next cycle.
REQ-031 Channel 1 full and stalled; send 0xDEADBEEF to sel 3 -> accepted immediately, o3 = 0xDEADBEEF, o1 unchanged.
REQ-032 o_ready[0] = 1, stream 8 words to sel 0 back-to-back -> in_ready stays 1, o_valid[0] stays 1 for 8 cycles, words delivered in order, xfer_count = 8.
REQ-033 Preload xfer_count to 0xFFFF via 65535 accepts, one more accept -> xfer_count = 0x0000.
REQ-034 Fill channels 0 and 3, assert rst_n = 0 mid-cycle -> o_valid = 0, o0..o3 = 0, xfer_count = 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/result_demux4.sv
// ============================================================================
// result_demux4 : routes a result word to one of four one-entry output channels
// Revision      : 1.0
// ============================================================================
`default_nettype none

module result_demux4 #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             s1,
  input  logic             S0,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ready,
  output logic [CNTW-1:0]  xfer_count,
  output logic             busy
);

  logic [1:0]       sel;
  logic             accept;
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;

  assign sel      = {s1, S0};
  // A full channel can still take a word when its consumer drains it this edge.
  assign in_ready = !valid_q[sel] | o_ready[sel];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic acc_k;

    always_comb begin
      acc_k      = accept && (sel == 2'(k));
      valid_d[k] = acc_k | (valid_q[k] & ~o_ready[k]);
      data_d[k]  = acc_k ? in_data : data_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end else begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o0         = data_q[0];
  assign o1         = data_q[1];
  assign o2         = data_q[2];
  assign o3         = data_q[3];
  assign o_valid    = valid_q;
  assign busy       = |valid_q;
  assign xfer_count = cnt_q;

endmodule

`default_nettype wire
